wino_tile_seq: RTL and testbench

- Stream-side driver/reader for the 1-D Winograd core WC (8 x 10-bit signed input tile D, 4 x 10-bit signed result Z).
- Accepts a serial 10-bit sample stream and builds overlapping 8-sample tiles with stride 4.
- Presents each tile to WC, waits the core settle time, captures Z, and serializes the four results onto an output stream.
- One tile in flight at a time.

---
 rtl/wino_tile_seq_if.sv | 24 ++
 rtl/wino_tile_seq.sv | 146 ++++++++++++++
 tb/tb_wino_tile_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wino_tile_seq_if.sv
// Sample/result stream bundle around the Winograd tile sequencer.
// slave = sequencer side, master = the stream endpoint feeding samples and taking results.
interface wino_tile_seq_if #(
  parameter int unsigned DW = 10
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/wino_tile_seq.sv
// Builds stride-4 overlapping 8-sample tiles for the Winograd core, waits its settle
// time, then serializes the four results onto the output stream.
module wino_tile_seq #(
  parameter int unsigned DW     = 10,
  parameter int unsigned WC_LAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  wino_tile_seq_if.slave    strm,
  output logic [8*DW-1:0]   wc_d,
  input  logic [4*DW-1:0]   wc_z,
  output logic              busy
);
  localparam int unsigned NW = 8;
  localparam int unsigned NZ = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {FILL, PAD, WAIT, DRAIN} state_e;

  state_e                  state, state_n;
  logic [NW-1:0][DW-1:0]   win, win_n;
  logic [NZ-1:0][DW-1:0]   outr, out_n;
  logic [CW-1:0]           need, need_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [1:0]              idx, idx_n;
  logic                    flag, flag_n;
  logic                    s_ready_q, s_ready_n;
  logic                    m_valid_q, m_valid_n;
  logic [DW-1:0]           m_data_q, m_data_n;
  logic                    m_last_q, m_last_n;
  logic                    busy_q, busy_n;
  logic                    hs_s, hs_m;

  assign hs_s        = strm.s_valid & s_ready_q;
  assign hs_m        = m_valid_q & strm.m_ready;
  assign wc_d        = win;
  assign busy        = busy_q;
  assign strm.s_ready = s_ready_q;
  assign strm.m_valid = m_valid_q;
  assign strm.m_data  = m_data_q;
  assign strm.m_last  = m_last_q;

  // Next-state and next-output logic; win[NW-1] is the oldest sample (top of wc_d).
  always_comb begin
    state_n   = state;
    win_n     = win;
    out_n     = outr;
    need_n    = need;
    cnt_n     = cnt;
    idx_n     = idx;
    flag_n    = flag;
    m_valid_n = m_valid_q;
    m_data_n  = m_data_q;
    m_last_n  = m_last_q;
    case (state)
      FILL: begin
        if (hs_s) begin
          win_n  = {win[NW-2:0], strm.s_data};
          need_n = need - CW'(1);
          if (strm.s_last) flag_n = 1'b1;
          if (need == CW'(1)) begin
            state_n = WAIT;
            cnt_n   = '0;
          end else if (strm.s_last) begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        win_n  = {win[NW-2:0], DW'(0)};
        need_n = need - CW'(1);
        if (need == CW'(1)) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (cnt == CW'(WC_LAT - 1)) begin
          out_n     = wc_z;
          state_n   = DRAIN;
          idx_n     = '0;
          m_valid_n = 1'b1;
          m_data_n  = wc_z[4*DW-1 -: DW];
          m_last_n  = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (hs_m) begin
          if (idx == 2'd3) begin
            state_n   = FILL;
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
            // Frame end restarts from an empty window; otherwise keep 4 samples of overlap.
            if (flag) begin
              win_n  = '0;
              need_n = CW'(8);
              flag_n = 1'b0;
            end else begin
              need_n = CW'(4);
            end
          end else begin
            idx_n    = idx + 2'd1;
            m_data_n = outr[2'd3 - idx_n];
            m_last_n = flag & (idx_n == 2'd3);
          end
        end
      end
      default: state_n = FILL;
    endcase
    s_ready_n = (state_n == FILL);
    busy_n    = !((state_n == FILL) && (need_n == CW'(8)));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      win       <= '0;
      outr      <= '0;
      need      <= CW'(8);
      cnt       <= '0;
      idx       <= '0;
      flag      <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      outr      <= out_n;
      need      <= need_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      flag      <= flag_n;
      s_ready_q <= s_ready_n;
      m_valid_q <= m_valid_n;
      m_data_q  <= m_data_n;
      m_last_q  <= m_last_n;
      busy_q    <= busy_n;
    end
  end
endmodule

// File: tb/tb_wino_tile_seq.sv
// Directed bench for wino_tile_seq with a behavioural Winograd core stand-in whose
// result only becomes visible WC_LAT cycles after the tile settles.
module tb_wino_tile_seq;
  localparam int unsigned DW     = 10;
  localparam int unsigned WC_LAT = 6;
  localparam int unsigned CWW    = 8 * DW;
  localparam int          LIM    = 100;

  localparam logic [CWW-1:0] TILE_A =
    80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100;
  localparam logic [CWW-1:0] TILE_B =
    {DW'(-19), DW'(-6), DW'(3), DW'(-9), DW'(-12), DW'(11), DW'(-4), DW'(0)};
  localparam logic [4*DW-1:0] Z_A = {DW'(15), DW'(-139), DW'(-420), DW'(-344)};
  localparam logic [4*DW-1:0] Z_B = {DW'(-223), DW'(-277), DW'(-63), DW'(-49)};

  logic            clk;
  logic            rst;
  logic [CWW-1:0]  wc_d;
  logic [4*DW-1:0] wc_z;
  logic            busy;
  int              n_vec = 0;
  int              n_err = 0;

  wino_tile_seq_if #(.DW(DW)) ifc ();

  wino_tile_seq #(.DW(DW), .WC_LAT(WC_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .strm (ifc.slave),
    .wc_d (wc_d),
    .wc_z (wc_z),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: the two reference tiles give their known results, any other tile
  // gives z_i = d_i + d_(i+4) (d_0 oldest, z_0 in the top slot).
  function automatic logic [4*DW-1:0] wc_model(input logic [CWW-1:0] d);
    logic [4*DW-1:0] z;
    if (d == TILE_A) return Z_A;
    if (d == TILE_B) return Z_B;
    z = '0;
    for (int i = 0; i < 4; i++)
      z[(3-i)*DW +: DW] = d[(7-i)*DW +: DW] + d[(3-i)*DW +: DW];
    return z;
  endfunction

  logic [4*DW-1:0] z_pipe [WC_LAT-1];
  always @(posedge clk) begin
    z_pipe[0] <= wc_model(wc_d);
    for (int i = 1; i < int'(WC_LAT) - 1; i++) z_pipe[i] <= z_pipe[i-1];
  end
  assign wc_z = z_pipe[WC_LAT-2];

  function automatic logic [CWW-1:0] pack8(input int v[8]);
    logic [CWW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[CWW-DW-1:0], DW'(v[i])};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CWW-1:0] got, input logic [CWW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v, input logic last);
    int g;
    g = 0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = DW'(v);
    ifc.s_last  = last;
    while (!ifc.s_ready && g < LIM) begin
      step(1);
      g++;
    end
    if (g >= LIM) chk("s_ready_timeout", CWW'(0), CWW'(1));
    step(1);
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  task automatic send8(input int v[8], input logic last);
    for (int i = 0; i < 8; i++) send(v[i], last && (i == 7));
  endtask

  task automatic wait_mv(output int n);
    n = 0;
    while (!ifc.m_valid && n < LIM) begin
      step(1);
      n++;
    end
  endtask

  task automatic recv(input string tag, input int exp, input logic last);
    int g;
    logic [DW-1:0] e;
    e = DW'(exp);
    wait_mv(g);
    if (g >= LIM) chk({tag, "_timeout"}, CWW'(0), CWW'(1));
    chk({tag, "_data"}, CWW'(ifc.m_data), CWW'(e));
    chk({tag, "_last"}, CWW'(ifc.m_last), CWW'(last));
    ifc.m_ready = 1'b1;
    step(1);
    ifc.m_ready = 1'b0;
  endtask

  task automatic recv4(input string tag, input int z[4], input logic last);
    for (int i = 0; i < 4; i++) recv(tag, z[i], last && (i == 3));
  endtask

  initial begin
    int n;
    int fa[8]  = '{2, -10, 3, 4, -13, -18, -16, -28};
    int fb[8]  = '{-19, -6, 3, -9, -12, 11, -4, 0};
    int ov1[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int ov2[8] = '{5, 6, 7, 8, 9, 10, 11, 12};
    int pd[8]  = '{1, 2, 3, 4, 5, 0, 0, 0};
    int bp[8]  = '{10, 20, 30, 40, 50, 60, 70, 80};
    int za[4]  = '{15, -139, -420, -344};
    int zb[4]  = '{-223, -277, -63, -49};
    int zo1[4] = '{6, 8, 10, 12};
    int zo2[4] = '{14, 16, 18, 20};
    int zp[4]  = '{6, 2, 3, 4};
    int zbp[4] = '{60, 80, 100, 120};

    rst = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.s_last  = 1'b0;
    ifc.m_ready = 1'b0;
    step(2);
    chk("rst_wc_d", wc_d, '0);
    chk("rst_m_valid", CWW'(ifc.m_valid), CWW'(0));
    chk("rst_m_data", CWW'(ifc.m_data), CWW'(0));
    chk("rst_m_last", CWW'(ifc.m_last), CWW'(0));
    chk("rst_s_ready", CWW'(ifc.s_ready), CWW'(0));
    chk("rst_busy", CWW'(busy), CWW'(0));
    #3 rst = 1'b1;
    step(1);
    chk("idle_s_ready", CWW'(ifc.s_ready), CWW'(1));
    chk("idle_busy", CWW'(busy), CWW'(0));

    // Frame A with the reference core values
    send8(fa, 1'b1);
    chk("a_wc_d", wc_d, TILE_A);
    chk("a_busy", CWW'(busy), CWW'(1));
    chk("a_s_ready", CWW'(ifc.s_ready), CWW'(0));
    wait_mv(n);
    chk("a_latency", CWW'(n), CWW'(WC_LAT));
    recv4("a", za, 1'b1);
    chk("a_end_m_valid", CWW'(ifc.m_valid), CWW'(0));
    chk("a_end_s_ready", CWW'(ifc.s_ready), CWW'(1));
    chk("a_end_cleared", wc_d, '0);
    chk("a_end_busy", CWW'(busy), CWW'(0));

    // Frame B, fresh window
    send8(fb, 1'b1);
    chk("b_wc_d", wc_d, TILE_B);
    recv4("b", zb, 1'b1);

    // Stride-4 overlap across two tiles
    send8(ov1, 1'b0);
    chk("ov1_wc_d", wc_d, pack8(ov1));
    recv4("ov1", zo1, 1'b0);
    chk("ov_keep_wc_d", wc_d, pack8(ov1));
    chk("ov_keep_busy", CWW'(busy), CWW'(1));
    for (int i = 9; i <= 12; i++) send(i, i == 12);
    chk("ov2_wc_d", wc_d, pack8(ov2));
    wait_mv(n);
    chk("ov2_latency", CWW'(n), CWW'(WC_LAT));
    recv4("ov2", zo2, 1'b1);

    // Short frame padded with zeros
    for (int i = 1; i <= 5; i++) send(i, i == 5);
    chk("pad_s_ready", CWW'(ifc.s_ready), CWW'(0));
    wait_mv(n);
    chk("pad_latency", CWW'(n), CWW'(3 + WC_LAT));
    chk("pad_wc_d", wc_d, pack8(pd));
    recv4("pad", zp, 1'b1);

    // Output backpressure: ready pattern 1-0-0-1
    send8(bp, 1'b1);
    recv("bp", zbp[0], 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("bp_hold_m_valid", CWW'(ifc.m_valid), CWW'(1));
      chk("bp_hold_m_data", CWW'(ifc.m_data), CWW'(DW'(zbp[1])));
      chk("bp_hold_s_ready", CWW'(ifc.s_ready), CWW'(0));
      step(1);
    end
    recv("bp", zbp[1], 1'b0);
    recv("bp", zbp[2], 1'b0);
    recv("bp", zbp[3], 1'b1);
    chk("bp_end_s_ready", CWW'(ifc.s_ready), CWW'(1));

    // Async reset in the middle of WAIT
    send8(ov1, 1'b1);
    step(2);
    #3 rst = 1'b0;
    #1;
    chk("rw_m_valid", CWW'(ifc.m_valid), CWW'(0));
    chk("rw_wc_d", wc_d, '0);
    chk("rw_s_ready", CWW'(ifc.s_ready), CWW'(0));
    chk("rw_busy", CWW'(busy), CWW'(0));
    #1 rst = 1'b1;
    step(1);

    // Async reset in the middle of DRAIN
    send8(bp, 1'b1);
    recv("rd", zbp[0], 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("rd_m_valid", CWW'(ifc.m_valid), CWW'(0));
    chk("rd_m_data", CWW'(ifc.m_data), CWW'(0));
    chk("rd_m_last", CWW'(ifc.m_last), CWW'(0));
    chk("rd_wc_d", wc_d, '0);
    chk("rd_busy", CWW'(busy), CWW'(0));
    #1 rst = 1'b1;
    step(1);

    // Fresh tile after reset
    send8(ov1, 1'b1);
    chk("post_wc_d", wc_d, pack8(ov1));
    wait_mv(n);
    chk("post_latency", CWW'(n), CWW'(WC_LAT));
    recv4("post", zo1, 1'b1);
    chk("post_end_s_ready", CWW'(ifc.s_ready), CWW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
